seven_seg_scan_ctrl: RTL

Sequential controller that drives a 3-digit multiplexed seven-segment display from an 8-bit binary value. It converts the value to BCD using an iterative shift-add-3 sequence over 8 clock cycles with a start/busy/done handshake. It holds the result in a display register and time-multiplexes the three digits with a refresh prescaler. It sits between the binary data source and the board's anode and segment pins.

---
 rtl/seven_seg_scan_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// 3-digit multiplexed seven-segment controller: 8-bit binary to BCD by
// iterative adjust-then-shift (double dabble), plus a free-running digit scan.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  value,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  sr;
    logic [3:0]  hun, ten, one;
    logic [2:0]  cnt;
    logic [3:0]  ten_a, one_a;
    logic [19:0] sh;
    logic [PW-1:0] presc;
    logic [1:0]  dig;
    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  glyph;

    function automatic logic [6:0] glyph_f(input logic [3:0] n);
        case (n)
            4'd0: glyph_f = 7'b0111111;
            4'd1: glyph_f = 7'b0000110;
            4'd2: glyph_f = 7'b1011011;
            4'd3: glyph_f = 7'b1001111;
            4'd4: glyph_f = 7'b1100110;
            4'd5: glyph_f = 7'b1101101;
            4'd6: glyph_f = 7'b1111101;
            4'd7: glyph_f = 7'b0000111;
            4'd8: glyph_f = 7'b1111111;
            4'd9: glyph_f = 7'b1101111;
            default: glyph_f = 7'b0000000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (cnt == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hundreds never exceeds 2, so only ones and tens need the +3 correction.
    always_comb begin
        one_a = (one >= 4'd5) ? one + 4'd3 : one;
        ten_a = (ten >= 4'd5) ? ten + 4'd3 : ten;
        sh    = {hun, ten_a, one_a, sr} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            hun <= '0;
            ten <= '0;
            one <= '0;
            cnt <= '0;
            bcd <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sr  <= value;
                    hun <= '0;
                    ten <= '0;
                    one <= '0;
                    cnt <= '0;
                end
                SHIFT: begin
                    {hun, ten, one, sr} <= sh;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) bcd <= sh[19:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            dig   <= '0;
        end else if (presc == PMAX) begin
            presc <= '0;
            dig   <= (dig == 2'd2) ? 2'd0 : dig + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A blanked digit keeps its anode enabled; only the segments go dark.
    always_comb begin
        an    = 3'b111;
        nib   = 4'd0;
        blank = 1'b0;
        case (dig)
            2'd0: begin
                an  = 3'b110;
                nib = bcd[3:0];
            end
            2'd1: begin
                an    = 3'b101;
                nib   = bcd[7:4];
                blank = BLANK_LZ && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            2'd2: begin
                an    = 3'b011;
                nib   = bcd[11:8];
                blank = BLANK_LZ && (bcd[11:8] == 4'd0);
            end
            default: blank = 1'b1;
        endcase
        glyph = blank ? 7'b0000000 : glyph_f(nib);
        seg   = ACTIVE_LOW_SEG ? ~glyph : glyph;
    end

endmodule
